// File: rtl/gerenciador_tiros.sv
// Shot manager: spawns shots at the ship, steps them on each tick and checks them one by one against asteroid memory.
// Optional build macro TIRO_WRAP_EN: shots wrap around the grid edges instead of being removed.
module gerenciador_tiros #(
    parameter int COORD_W = 4,
    parameter int N_TIROS = 4
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               disparo,
    input  logic [COORD_W-1:0] nave_x,
    input  logic [COORD_W-1:0] nave_y,
    input  logic [1:0]         opcode,
    input  logic               tick,
    output logic [COORD_W-1:0] consulta_x,
    output logic [COORD_W-1:0] consulta_y,
    output logic               consulta_valid,
    input  logic               aste_presente,
    output logic               destruido,
    output logic [COORD_W-1:0] destruido_x,
    output logic [COORD_W-1:0] destruido_y,
    output logic [N_TIROS-1:0] ativos,
    output logic               cheio,
    output logic               pronto,
    output logic               fim_passo
);

    localparam int IDX_W = (N_TIROS > 1) ? $clog2(N_TIROS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_TIROS - 1);
    localparam logic [COORD_W-1:0] COORD_MAX = '1;
`ifdef TIRO_WRAP_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, MOVE, CHECK, FIM} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [COORD_W-1:0] x_q [N_TIROS];
    logic [COORD_W-1:0] y_q [N_TIROS];
    logic [1:0]         dir_q [N_TIROS];
    logic [COORD_W-1:0] x_d [N_TIROS];
    logic [COORD_W-1:0] y_d [N_TIROS];
    logic [1:0]         dir_d [N_TIROS];
    logic [N_TIROS-1:0] ativo_q, ativo_d;
    logic               dest_q, dest_d;
    logic [COORD_W-1:0] dest_x_q, dest_x_d, dest_y_q, dest_y_d;

    logic [COORD_W-1:0] step_x [N_TIROS];
    logic [COORD_W-1:0] step_y [N_TIROS];
    logic [N_TIROS-1:0] sai;
    logic               livre_ok;
    logic [IDX_W-1:0]   livre_idx;

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            ativo_q  <= '0;
            dest_q   <= 1'b0;
            dest_x_q <= '0;
            dest_y_q <= '0;
            for (int i = 0; i < N_TIROS; i++) begin
                x_q[i]   <= '0;
                y_q[i]   <= '0;
                dir_q[i] <= 2'b00;
            end
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            ativo_q  <= ativo_d;
            dest_q   <= dest_d;
            dest_x_q <= dest_x_d;
            dest_y_q <= dest_y_d;
            x_q      <= x_d;
            y_q      <= y_d;
            dir_q    <= dir_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE:  if (tick) state_d = MOVE;
            MOVE:  begin
                state_d = CHECK;
                idx_d   = '0;
            end
            CHECK: begin
                if (idx_q == IDX_LAST) state_d = FIM;
                else                   idx_d   = idx_q + IDX_W'(1);
            end
            FIM:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Lowest-index free slot; scanning downwards leaves the smallest index last.
    always_comb begin
        livre_ok  = 1'b0;
        livre_idx = '0;
        for (int i = N_TIROS - 1; i >= 0; i--) begin
            if (!ativo_q[i]) begin
                livre_ok  = 1'b1;
                livre_idx = IDX_W'(i);
            end
        end
    end

    // One-cell step per slot; coordinate arithmetic wraps naturally, sai flags an edge crossing.
    always_comb begin
        for (int i = 0; i < N_TIROS; i++) begin
            step_x[i] = x_q[i];
            step_y[i] = y_q[i];
            sai[i]    = 1'b0;
            case (dir_q[i])
                2'b00: begin
                    step_y[i] = y_q[i] - COORD_W'(1);
                    sai[i]    = (y_q[i] == '0);
                end
                2'b01: begin
                    step_x[i] = x_q[i] + COORD_W'(1);
                    sai[i]    = (x_q[i] == COORD_MAX);
                end
                2'b10: begin
                    step_y[i] = y_q[i] + COORD_W'(1);
                    sai[i]    = (y_q[i] == COORD_MAX);
                end
                default: begin
                    step_x[i] = x_q[i] - COORD_W'(1);
                    sai[i]    = (x_q[i] == '0);
                end
            endcase
        end
    end

    // Slot datapath: spawn in IDLE, step in MOVE, clear on hit in CHECK
    always_comb begin
        x_d      = x_q;
        y_d      = y_q;
        dir_d    = dir_q;
        ativo_d  = ativo_q;
        dest_d   = 1'b0;
        dest_x_d = dest_x_q;
        dest_y_d = dest_y_q;
        case (state_q)
            IDLE: begin
                if (disparo && livre_ok) begin
                    x_d[livre_idx]     = nave_x;
                    y_d[livre_idx]     = nave_y;
                    dir_d[livre_idx]   = opcode;
                    ativo_d[livre_idx] = 1'b1;
                end
            end
            MOVE: begin
                for (int i = 0; i < N_TIROS; i++) begin
                    if (ativo_q[i]) begin
                        x_d[i] = step_x[i];
                        y_d[i] = step_y[i];
                        if (!WRAP_EN && sai[i]) ativo_d[i] = 1'b0;
                    end
                end
            end
            CHECK: begin
                if (ativo_q[idx_q] && aste_presente) begin
                    ativo_d[idx_q] = 1'b0;
                    dest_d         = 1'b1;
                    dest_x_d       = x_q[idx_q];
                    dest_y_d       = y_q[idx_q];
                end
            end
            default: ;
        endcase
    end

    // Outputs
    always_comb begin
        pronto         = (state_q == IDLE);
        fim_passo      = (state_q == FIM);
        consulta_valid = (state_q == CHECK) && ativo_q[idx_q];
        consulta_x     = consulta_valid ? x_q[idx_q] : '0;
        consulta_y     = consulta_valid ? y_q[idx_q] : '0;
        destruido      = dest_q;
        destruido_x    = dest_x_q;
        destruido_y    = dest_y_q;
        ativos         = ativo_q;
        cheio          = &ativo_q;
    end

endmodule

// File: tb/tb_gerenciador_tiros.sv
// Bench for gerenciador_tiros: directed scenarios plus random traffic checked against a slot-list model.
module tb_gerenciador_tiros;

    localparam int CW = 4;
    localparam int NT = 4;
    localparam int G  = 16;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          disparo;
    logic [CW-1:0] nave_x, nave_y;
    logic [1:0]    opcode;
    logic          tick;
    logic [CW-1:0] consulta_x, consulta_y;
    logic          consulta_valid;
    logic          aste_presente;
    logic          destruido;
    logic [CW-1:0] destruido_x, destruido_y;
    logic [NT-1:0] ativos;
    logic          cheio, pronto, fim_passo;

    gerenciador_tiros #(.COORD_W(CW), .N_TIROS(NT)) dut (
        .clock(clock), .reset_n(reset_n), .disparo(disparo),
        .nave_x(nave_x), .nave_y(nave_y), .opcode(opcode), .tick(tick),
        .consulta_x(consulta_x), .consulta_y(consulta_y),
        .consulta_valid(consulta_valid), .aste_presente(aste_presente),
        .destruido(destruido), .destruido_x(destruido_x), .destruido_y(destruido_y),
        .ativos(ativos), .cheio(cheio), .pronto(pronto), .fim_passo(fim_passo)
    );

    always #5 clock = ~clock;

    // Reference model: list of shots and an asteroid field
    int mx [NT];
    int my [NT];
    int mdir [NT];
    bit mact [NT];
    bit ast [G][G];
    int last_x, last_y;
    int n_checks = 0, n_pass = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [NT-1:0] act_vec();
        logic [NT-1:0] v;
        for (int i = 0; i < NT; i++) v[i] = mact[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NT; i++) begin
            mact[i] = 1'b0; mx[i] = 0; my[i] = 0; mdir[i] = 0;
        end
        last_x = 0;
        last_y = 0;
    endtask

    task automatic clear_ast();
        for (int a = 0; a < G; a++)
            for (int b = 0; b < G; b++) ast[a][b] = 1'b0;
    endtask

    task automatic model_spawn(input int x, input int y, input int d);
        for (int i = 0; i < NT; i++) begin
            if (!mact[i]) begin
                mact[i] = 1'b1; mx[i] = x; my[i] = y; mdir[i] = d;
                return;
            end
        end
    endtask

    task automatic next_pos(input int i, output int nx, output int ny);
        nx = mx[i] + ((mdir[i] == 1) ? 1 : (mdir[i] == 3) ? -1 : 0);
        ny = my[i] + ((mdir[i] == 2) ? 1 : (mdir[i] == 0) ? -1 : 0);
    endtask

    task automatic model_move();
        int nx, ny;
        for (int i = 0; i < NT; i++) begin
            if (mact[i]) begin
                next_pos(i, nx, ny);
`ifdef TIRO_WRAP_EN
                nx = (nx + G) % G;
                ny = (ny + G) % G;
`else
                if (nx < 0 || nx >= G || ny < 0 || ny >= G) mact[i] = 1'b0;
`endif
                mx[i] = nx;
                my[i] = ny;
            end
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, " ativos"}, 32'(ativos), 32'(act_vec()));
        chk({tag, " cheio"}, 32'(cheio), 32'(&act_vec()));
        chk({tag, " pronto"}, 32'(pronto), 32'd1);
        chk({tag, " consulta_valid"}, 32'(consulta_valid), 32'd0);
        chk({tag, " fim_passo"}, 32'(fim_passo), 32'd0);
        chk({tag, " destruido"}, 32'(destruido), 32'd0);
        chk({tag, " destruido_x"}, 32'(destruido_x), 32'(last_x));
        chk({tag, " destruido_y"}, 32'(destruido_y), 32'(last_y));
    endtask

    task automatic fire(input string tag, input int x, input int y, input int d);
        nave_x = CW'(x); nave_y = CW'(y); opcode = 2'(d);
        disparo = 1'b1;
        model_spawn(x, y, d);
        cyc();
        disparo = 1'b0;
        check_idle(tag);
    endtask

    // One full update pass; stray: 0 quiet, 1 random tick/disparo, 2 disparo held high
    task automatic run_pass(input string tag, input bit with_fire, input int stray);
        bit hit, hit_prev;
        tick = 1'b1;
        disparo = with_fire;
        if (with_fire) model_spawn(int'(nave_x), int'(nave_y), int'(opcode));
        cyc();
        tick    = (stray == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        disparo = (stray == 2) ? 1'b1 : (stray == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        chk({tag, " move pronto"}, 32'(pronto), 32'd0);
        chk({tag, " move consulta_valid"}, 32'(consulta_valid), 32'd0);
        model_move();
        cyc();
        hit_prev = 1'b0;
        for (int i = 0; i < NT; i++) begin
            if (stray == 1) tick = 1'($urandom_range(0, 1));
            chk($sformatf("%s check%0d consulta_valid", tag, i), 32'(consulta_valid), 32'(mact[i]));
            if (mact[i]) begin
                chk($sformatf("%s check%0d consulta_x", tag, i), 32'(consulta_x), 32'(mx[i]));
                chk($sformatf("%s check%0d consulta_y", tag, i), 32'(consulta_y), 32'(my[i]));
            end
            chk($sformatf("%s check%0d destruido", tag, i), 32'(destruido), 32'(hit_prev));
            chk($sformatf("%s check%0d destruido_x", tag, i), 32'(destruido_x), 32'(last_x));
            chk($sformatf("%s check%0d fim_passo", tag, i), 32'(fim_passo), 32'd0);
            hit = mact[i] && ast[mx[i]][my[i]];
            aste_presente = mact[i] ? hit : 1'($urandom_range(0, 1));
            if (hit) begin
                mact[i] = 1'b0;
                ast[mx[i]][my[i]] = 1'b0;
                last_x = mx[i];
                last_y = my[i];
            end
            hit_prev = hit;
            cyc();
        end
        aste_presente = 1'b0;
        chk({tag, " fim fim_passo"}, 32'(fim_passo), 32'd1);
        chk({tag, " fim pronto"}, 32'(pronto), 32'd0);
        chk({tag, " fim consulta_valid"}, 32'(consulta_valid), 32'd0);
        chk({tag, " fim destruido"}, 32'(destruido), 32'(hit_prev));
        chk({tag, " fim destruido_y"}, 32'(destruido_y), 32'(last_y));
        chk({tag, " fim ativos"}, 32'(ativos), 32'(act_vec()));
        tick = 1'b0;
        disparo = 1'b0;
        cyc();
        check_idle({tag, " idle"});
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, " pronto"}, 32'(pronto), 32'd1);
        chk({tag, " ativos"}, 32'(ativos), 32'd0);
        chk({tag, " cheio"}, 32'(cheio), 32'd0);
        chk({tag, " destruido"}, 32'(destruido), 32'd0);
        chk({tag, " fim_passo"}, 32'(fim_passo), 32'd0);
        chk({tag, " consulta_valid"}, 32'(consulta_valid), 32'd0);
        chk({tag, " consulta_xy"}, 32'({consulta_x, consulta_y}), 32'd0);
        chk({tag, " destruido_xy"}, 32'({destruido_x, destruido_y}), 32'd0);
    endtask

    initial begin
        int r, i, nx, ny;
        reset_n = 1'b0; disparo = 1'b0; tick = 1'b0; aste_presente = 1'b0;
        nave_x = '0; nave_y = '0; opcode = 2'b00;
        model_reset();
        clear_ast();
        cyc();
        check_reset_outputs("reset");
        cyc();
        reset_n = 1'b1;
        check_idle("after reset");

        // Shot leaving the top edge
        fire("s1 fire", 7, 0, 0);
        run_pass("s1 pass", 1'b0, 0);

        // Hit at (4,5)
        ast[4][5] = 1'b1;
        fire("s2 fire", 3, 5, 1);
        run_pass("s2 pass", 1'b0, 0);
        chk("s2 destruido_x", 32'(destruido_x), 32'd4);
        chk("s2 destruido_y", 32'(destruido_y), 32'd5);

        // Fill every slot, fifth request ignored, then a quiet pass
        fire("s3 fire0", 5, 5, 0);
        fire("s3 fire1", 6, 6, 1);
        fire("s3 fire2", 7, 7, 2);
        fire("s3 fire3", 8, 8, 3);
        chk("s3 cheio", 32'(cheio), 32'd1);
        fire("s3 fire4", 1, 1, 1);
        run_pass("s3 pass", 1'b0, 0);

        // Reset during CHECK index 2
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        cyc();
        cyc();
        cyc();
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_reset_outputs("s5 async reset");
        cyc();
        cyc();
        check_reset_outputs("s5 held reset");
        reset_n = 1'b1;
        check_idle("s5 released");

        // Tick with disparo together; new shot moves in the same pass
        nave_x = 4'd2; nave_y = 4'd2; opcode = 2'b10;
        run_pass("s4 pass", 1'b1, 0);
        chk("s4 ativos", 32'(ativos), 32'b0001);

        // disparo held high throughout a pass is ignored
        run_pass("s6 pass", 1'b0, 2);

        // Random traffic
        for (int it = 0; it < 40; it++) begin
            r = $urandom_range(0, 3);
            if (r < 2) begin
                fire($sformatf("rnd%0d fire", it), $urandom_range(0, G - 1),
                     $urandom_range(0, G - 1), $urandom_range(0, 3));
            end else begin
                ast[$urandom_range(0, G - 1)][$urandom_range(0, G - 1)] = 1'b1;
                i = $urandom_range(0, NT - 1);
                if (mact[i] && $urandom_range(0, 1) == 1) begin
                    next_pos(i, nx, ny);
                    if (nx >= 0 && nx < G && ny >= 0 && ny < G) ast[nx][ny] = 1'b1;
                end
                nave_x = CW'($urandom_range(0, G - 1));
                nave_y = CW'($urandom_range(0, G - 1));
                opcode = 2'($urandom_range(0, 3));
                run_pass($sformatf("rnd%0d pass", it), r == 3, 1);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
